// File: rtl/kernel_pkg.sv
// kernel_pkg: shared definitions for the kernel load path.
//   state_t          - load controller FSM states
//   KERNEL_WORDS     - words per kernel (PE_COUNT * TAPS_PER_PE)
//   PE_COUNT         - processing elements fed by the shift buffer
//   TAPS_PER_PE      - taps held per processing element
//   DEFAULT_DATA_W   - default signed kernel word width
//   ISSUE_CNT_W      - width of the read-issue counter (0..KERNEL_WORDS-1)
package kernel_pkg;

  localparam int KERNEL_WORDS   = 36;
  localparam int PE_COUNT       = 4;
  localparam int TAPS_PER_PE    = 9;
  localparam int DEFAULT_DATA_W = 16;
  localparam int ISSUE_CNT_W    = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DRAIN  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/kernel_load_ctrl.sv
// kernel_load_ctrl: streams one 36-word kernel from weight memory into the
// kernel shift buffer.
//
// Ports:
//   clk, rst         - clock (rising edge), asynchronous active-high reset
//   start, base_addr - load request; base_addr sampled on an accepted start
//   abort            - synchronous cancel, wins over everything else
//   stall            - memory busy; suppresses the read issue this cycle
//   w_ren, w_addr    - weight-memory read port
//   w_rdata          - read data, valid the cycle after w_ren
//   pe_ready, kernal - shift enable and word into the shift buffer
//   busy, done       - not-IDLE level; one-cycle completion pulse
//   kernels_valid    - buffer outputs coherent (set entering DONE)
//   stall_cycles     - stall count of the last load
//   state_dbg        - current FSM state
//
// Handshake: a read is issued on every clock edge where w_ren is high
// (w_ren = FETCH && !stall); its data returns on w_rdata one cycle later,
// which is exactly the cycle pe_ready is high, so the buffer shifts in
// kernal on the edge that closes that cycle. There is no back-pressure
// from the buffer.
//
// Build option: define KLC_STALL_CNT_EN to include the saturating stall
// counter; otherwise stall_cycles is tied to zero.
module kernel_load_ctrl
  import kernel_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              abort,
  input  logic              stall,
  output logic              w_ren,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic              pe_ready,
  output logic [DATA_W-1:0] kernal,
  output logic              busy,
  output logic              done,
  output logic              kernels_valid,
  output logic [15:0]       stall_cycles,
  output state_t            state_dbg
);

  localparam logic [ISSUE_CNT_W-1:0] LAST_ISSUE = ISSUE_CNT_W'(KERNEL_WORDS - 1);

  state_t                 state;
  state_t                 state_nx;
  logic [ISSUE_CNT_W-1:0] issue_count;
  logic [ADDR_W-1:0]      base_q;
  logic                   pe_ready_q;
  logic                   kvalid_q;
  logic                   start_acc;
  logic                   issue;

  // Next-state and strobes. abort overrides every transition, including
  // an IDLE start in the same cycle.
  always_comb begin
    state_nx  = state;
    start_acc = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nx  = FETCH;
        end
      end
      FETCH: begin
        issue = !stall;
        if (!stall && issue_count == LAST_ISSUE) state_nx = DRAIN;
      end
      DRAIN:   state_nx = SETTLE;  // final shift into the buffer
      SETTLE:  state_nx = DONE;    // buffer output register update
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx  = IDLE;
      start_acc = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      issue_count <= '0;
      base_q      <= '0;
      pe_ready_q  <= 1'b0;
      kvalid_q    <= 1'b0;
    end else begin
      state <= state_nx;
      // A read issued in the abort cycle must not produce a shift.
      pe_ready_q <= w_ren && !abort;
      if (start_acc) begin
        base_q      <= base_addr;
        issue_count <= '0;
        kvalid_q    <= 1'b0;
      end else if (abort) begin
        issue_count <= '0;
        kvalid_q    <= 1'b0;
      end else begin
        if (issue) issue_count <= issue_count + 1'b1;
        if (state == SETTLE) kvalid_q <= 1'b1;
      end
    end
  end

  assign w_ren         = (state == FETCH) && !stall;
  assign w_addr        = base_q + ADDR_W'(issue_count);
  assign pe_ready      = pe_ready_q;
  assign kernal        = pe_ready_q ? w_rdata : '0;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign kernels_valid = kvalid_q;
  assign state_dbg     = state;

`ifdef KLC_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (start_acc) begin
      stall_cnt_q <= '0;
    end else if (state == FETCH && stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_kernel_load_ctrl.sv
// tb_kernel_load_ctrl: directed bench for kernel_load_ctrl with a memory
// model, an address/word scoreboard and a done-latency check per load.
module tb_kernel_load_ctrl;
  import kernel_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic        abort;
  logic        stall;
  logic        w_ren;
  logic [15:0] w_addr;
  logic [15:0] w_rdata;
  logic        pe_ready;
  logic [15:0] kernal;
  logic        busy;
  logic        done;
  logic        kernels_valid;
  logic [15:0] stall_cycles;
  state_t      state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic [15:0] exp_q[$];   // expected kernel words in delivery order
  logic [15:0] addr_q[$];  // expected read addresses in issue order
  logic [15:0] sbuf[KERNEL_WORDS];

`ifdef KLC_STALL_CNT_EN
  localparam logic [15:0] EXP_STALL5 = 16'd5;
`else
  localparam logic [15:0] EXP_STALL5 = 16'd0;
`endif

  kernel_load_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .abort(abort), .stall(stall), .w_ren(w_ren), .w_addr(w_addr),
    .w_rdata(w_rdata), .pe_ready(pe_ready), .kernal(kernal), .busy(busy),
    .done(done), .kernels_valid(kernels_valid),
    .stall_cycles(stall_cycles), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  function automatic logic [15:0] mem_f(input logic [15:0] a);
    logic [15:0] r;
    r = a * 16'd7 + 16'h1234;
    return r;
  endfunction

  always @(posedge clk) begin
    if (w_ren) w_rdata <= mem_f(w_addr);
    else       w_rdata <= 16'hDEAD;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected queues whenever the DUT issues a read or
  // presents a word, and keeps a model of the downstream shift buffer.
  always @(negedge clk) begin
    if (!rst) begin
      if (w_ren) begin
        if (addr_q.size() == 0) check("w_addr_extra", {16'd0, w_addr}, 32'hFFFF_FFFF);
        else check("w_addr", {16'd0, w_addr}, {16'd0, addr_q.pop_front()});
      end
      if (pe_ready) begin
        if (exp_q.size() == 0) check("kernal_extra", {16'd0, kernal}, 32'hFFFF_FFFF);
        else check("kernal", {16'd0, kernal}, {16'd0, exp_q.pop_front()});
        for (int i = 0; i < KERNEL_WORDS - 1; i++) sbuf[i] = sbuf[i+1];
        sbuf[KERNEL_WORDS-1] = kernal;
      end else begin
        check("kernal_idle", {16'd0, kernal}, 32'd0);
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_w_ren"}, {31'd0, w_ren}, 32'd0);
    check({tag, "_pe_ready"}, {31'd0, pe_ready}, 32'd0);
    check({tag, "_kernal"}, {16'd0, kernal}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_kvalid"}, {31'd0, kernels_valid}, 32'd0);
    check({tag, "_stall_cycles"}, {16'd0, stall_cycles}, 32'd0);
    check({tag, "_state"}, {29'd0, state_dbg}, {29'd0, IDLE});
  endtask

  // One load. Cycle c is the cycle after edge E_c, E_0 being the edge that
  // accepts start. stall is high for cycles [sa, sa+sl); abort pulses in
  // cycle aa; start re-pulses (with a different base) in cycle ra; rst is
  // asserted at the start of cycle da. n_words/n_addrs are how many words
  // and read addresses must appear. done_c returns the cycle done was seen.
  task automatic run_load(input logic [15:0] base, input int sa, input int sl,
                          input int aa, input int ra, input int da,
                          input int n_words, input int n_addrs, output int done_c);
    int c;
    logic [15:0] a;
    for (int i = 0; i < n_addrs; i++) begin
      a = base + 16'(i);
      addr_q.push_back(a);
    end
    for (int i = 0; i < n_words; i++) begin
      a = base + 16'(i);
      exp_q.push_back(mem_f(a));
    end
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("kvalid_clear_on_start", {31'd0, kernels_valid}, 32'd0);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    c = 0;
    done_c = -1;
    while (c < 120 && done_c < 0) begin
      stall = (c >= sa) && (c < sa + sl);
      abort = (c == aa);
      start = (c == ra);
      base_addr = (c == ra) ? 16'h5555 : base;
      if (c == da) begin
        rst = 1'b1;
        #2;
        check_all_zero("rst_drain");
        rst = 1'b0;
        c = 1000;
      end else begin
        tick();
        c++;
        if (done) done_c = c;
        if (aa >= 0 && c == aa + 1) begin
          check("abort_state", {29'd0, state_dbg}, {29'd0, IDLE});
          check("abort_pe_ready", {31'd0, pe_ready}, 32'd0);
          check("abort_busy", {31'd0, busy}, 32'd0);
        end
      end
    end
    stall = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    base_addr = base;
  endtask

  task automatic check_complete(input string tag, input logic [15:0] base, input int done_c,
                                input int exp_lat);
    logic [15:0] last;
    last = base + 16'd35;
    check({tag, "_done_latency"}, 32'(done_c), 32'(exp_lat));
    check({tag, "_kvalid"}, {31'd0, kernels_valid}, 32'd1);
    check({tag, "_tap0"}, {16'd0, sbuf[0]}, {16'd0, mem_f(base)});
    check({tag, "_tap35"}, {16'd0, sbuf[KERNEL_WORDS-1]}, {16'd0, mem_f(last)});
    check({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_addrs_left"}, 32'(addr_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dc;
    rst = 1'b1;
    start = 1'b0;
    base_addr = 16'h0;
    abort = 1'b0;
    stall = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    check("reset_w_addr", {16'd0, w_addr}, 32'd0);
    rst = 1'b0;
    tick();

    // Plain load, no stall.
    run_load(16'h0100, -1, 0, -1, -1, -1, 36, 36, dc);
    check_complete("plain", 16'h0100, dc, 38);
    check("plain_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    tick();
    check("plain_done_pulse", {31'd0, done}, 32'd0);
    check("plain_idle_busy", {31'd0, busy}, 32'd0);
    check("plain_kvalid_hold", {31'd0, kernels_valid}, 32'd1);

    // Stall for 5 cycles at issue 10.
    run_load(16'h0200, 10, 5, -1, -1, -1, 36, 36, dc);
    check_complete("stall5", 16'h0200, dc, 43);
    check("stall5_count", {16'd0, stall_cycles}, {16'd0, EXP_STALL5});
    tick();
    tick();
    check("stall5_count_hold", {16'd0, stall_cycles}, {16'd0, EXP_STALL5});

    // Abort at issue 20: words 0..19 delivered, reads 0..20 issued.
    run_load(16'h0300, -1, 0, 20, -1, -1, 20, 21, dc);
    check("abort_no_done", 32'(dc), 32'hFFFF_FFFF);
    check("abort_kvalid", {31'd0, kernels_valid}, 32'd0);
    check("abort_words_left", 32'(exp_q.size()), 32'd0);
    check("abort_addrs_left", 32'(addr_q.size()), 32'd0);

    // abort and start together in IDLE: start dropped.
    abort = 1'b1;
    start = 1'b1;
    base_addr = 16'h7777;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_start_busy", {31'd0, busy}, 32'd0);
    check("abort_start_state", {29'd0, state_dbg}, {29'd0, IDLE});
    tick();

    // Full load after the abort.
    run_load(16'h0400, -1, 0, -1, -1, -1, 36, 36, dc);
    check_complete("after_abort", 16'h0400, dc, 38);
    tick();

    // start re-pulsed during FETCH is ignored.
    run_load(16'h0500, -1, 0, -1, 15, -1, 36, 36, dc);
    check_complete("repulse", 16'h0500, dc, 38);
    tick();

    // Address wrap.
    run_load(16'hFFF0, -1, 0, -1, -1, -1, 36, 36, dc);
    check_complete("wrap", 16'hFFF0, dc, 38);
    tick();

    // stall only from DRAIN onward has no effect.
    run_load(16'h0800, 36, 10, -1, -1, -1, 36, 36, dc);
    check_complete("late_stall", 16'h0800, dc, 38);
    check("late_stall_count", {16'd0, stall_cycles}, 32'd0);
    tick();

    // rst during DRAIN: words 0..34 shifted, all 36 reads issued.
    run_load(16'h0600, -1, 0, -1, -1, 36, 35, 36, dc);
    check("rst_no_done", 32'(dc), 32'hFFFF_FFFF);
    tick();
    tick();
    tick();
    check_all_zero("post_rst");
    check("rst_words_left", 32'(exp_q.size()), 32'd0);
    check("rst_addrs_left", 32'(addr_q.size()), 32'd0);

    check("done_pulse_total", 32'(done_cnt), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
